// File: rtl/gnn_conv_pkg.sv
// Shared definitions for the graph-conv datapath.
// Contents: sequencer FSM state enum, default feature/weight widths,
// accumulator width and index width helpers, packed-vector lane slicing helper.
package gnn_conv_pkg;

  // Sequencer states for the weight walk / multiply-accumulate stage
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } seq_state_e;

  localparam int unsigned F_WIDTH_DEF = 8;
  localparam int unsigned W_WIDTH_DEF = 8;

  // Accumulator width that cannot overflow for in_c full-scale products
  function automatic int unsigned acc_width(input int unsigned f,
                                            input int unsigned w,
                                            input int unsigned in_c);
    return f + w + $clog2(in_c);
  endfunction

  // Row index width; kept at least 1 bit so a single-row walk still has an address
  function automatic int unsigned idx_width(input int unsigned in_c);
    return (in_c > 1) ? $clog2(in_c) : 1;
  endfunction

  // LSB position of lane 'lane' in a packed vector of 'width'-bit lanes
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : clear accumulator to zero (takes priority over en_i)
//   en_i      : accumulate feat_i * w_i this cycle
//   feat_i    : signed feature operand
//   w_i       : signed weight operand
//   acc_o     : registered signed running sum (wraps modulo 2^ACC_WIDTH)
module mac_lane
  import gnn_conv_pkg::*;
#(
  parameter int unsigned F_WIDTH   = F_WIDTH_DEF,
  parameter int unsigned W_WIDTH   = W_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH = acc_width(F_WIDTH_DEF, W_WIDTH_DEF, 34)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic signed [F_WIDTH-1:0]   feat_i,
  input  logic signed [W_WIDTH-1:0]   w_i,
  output logic signed [ACC_WIDTH-1:0] acc_o
);

  localparam int unsigned P_WIDTH = F_WIDTH + W_WIDTH;

  logic signed [P_WIDTH-1:0]   prod_c;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [ACC_WIDTH-1:0] acc_q;

  // Full-precision signed product; operands sign-extend before the multiply
  assign prod_c = P_WIDTH'(feat_i) * P_WIDTH'(w_i);

  // Next accumulator value
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_WIDTH'(prod_c);
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/w_mac_seq.sv
// Weight-row sequencer and multiply-accumulate stage downstream of w_mat.
// Accepts one feature vector, walks weight rows 0..IN_C-1, accumulates
// feat[k] * w_row_k[j] into OUT_C lanes, then offers the sums downstream.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   in_vld/in_rdy : feature vector handshake; in_feat_pack holds IN_C features
//   w_rd_en       : weight memory read enable
//   w_in_c_idx    : weight row address
//   w_vec_pack    : weight row, valid one cycle after w_rd_en
//   out_vld/out_rdy : result handshake; out_acc_pack holds OUT_C sums
module w_mac_seq
  import gnn_conv_pkg::*;
#(
  parameter int unsigned IN_C      = 34,
  parameter int unsigned OUT_C     = 32,
  parameter int unsigned W_WIDTH   = W_WIDTH_DEF,
  parameter int unsigned F_WIDTH   = F_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH = acc_width(F_WIDTH, W_WIDTH, IN_C)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [IN_C*F_WIDTH-1:0]      in_feat_pack,
  output logic                         w_rd_en,
  output logic [idx_width(IN_C)-1:0]   w_in_c_idx,
  input  logic [OUT_C*W_WIDTH-1:0]     w_vec_pack,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [OUT_C*ACC_WIDTH-1:0]   out_acc_pack
);

  localparam int unsigned IN_C_WIDTH = idx_width(IN_C);
  localparam logic [IN_C_WIDTH-1:0] IDX_LAST = IN_C_WIDTH'(IN_C - 1);

  seq_state_e                state_q;
  logic                      in_rdy_q;
  logic                      out_vld_q;
  logic                      rd_en_q;
  logic [IN_C_WIDTH-1:0]     idx_q;
  logic                      rd_vld_q;   // w_vec_pack valid this cycle
  logic [IN_C_WIDTH-1:0]     idx_d_q;    // row index that w_vec_pack belongs to
  logic signed [F_WIDTH-1:0] feat_q [IN_C];

  logic                      acc_clr_c;
  logic signed [F_WIDTH-1:0] feat_sel_c;

  // Accumulators clear on the same edge that accepts a new vector
  assign acc_clr_c  = (state_q == IDLE) && in_vld && in_rdy_q;
  assign feat_sel_c = feat_q[idx_d_q];

  // Sequencer FSM, row counter, feature latch and read pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      rd_en_q   <= 1'b0;
      idx_q     <= '0;
      rd_vld_q  <= 1'b0;
      idx_d_q   <= '0;
      for (int k = 0; k < int'(IN_C); k++) begin
        feat_q[k] <= '0;
      end
    end else begin
      // Weight data returns one cycle after the address
      rd_vld_q <= rd_en_q;
      idx_d_q  <= idx_q;

      case (state_q)
        IDLE: begin
          if (in_vld && in_rdy_q) begin
            for (int k = 0; k < int'(IN_C); k++) begin
              feat_q[k] <= in_feat_pack[lane_lsb(k, F_WIDTH) +: F_WIDTH];
            end
            idx_q    <= '0;
            rd_en_q  <= 1'b1;
            in_rdy_q <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (idx_q == IDX_LAST) begin
            idx_q   <= '0;
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            idx_q <= idx_q + IN_C_WIDTH'(1);
          end
        end
        DRAIN: begin
          // Last row is accumulated on this edge
          out_vld_q <= 1'b1;
          state_q   <= OUT;
        end
        OUT: begin
          if (out_rdy) begin
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // One MAC lane per output channel
  for (genvar j = 0; j < int'(OUT_C); j++) begin : g_lane
    mac_lane #(
      .F_WIDTH  (F_WIDTH),
      .W_WIDTH  (W_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr_i (acc_clr_c),
      .en_i  (rd_vld_q),
      .feat_i(feat_sel_c),
      .w_i   (w_vec_pack[lane_lsb(j, W_WIDTH) +: W_WIDTH]),
      .acc_o (out_acc_pack[lane_lsb(j, ACC_WIDTH) +: ACC_WIDTH])
    );
  end

  assign in_rdy     = in_rdy_q;
  assign out_vld    = out_vld_q;
  assign w_rd_en    = rd_en_q;
  assign w_in_c_idx = idx_q;

endmodule

// File: tb/tb_w_mac_seq.sv
// Self-checking bench for w_mac_seq (IN_C=4, OUT_C=2, 8-bit operands).
// A timeline model predicts handshake/read behaviour per cycle and the lane
// sums as plain dot products; directed cases pin the model with literal values.
module tb_w_mac_seq;

  localparam int IN_C  = 4;
  localparam int OUT_C = 2;
  localparam int FW    = 8;
  localparam int WW    = 8;
  localparam int ACC   = FW + WW + $clog2(IN_C);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_vld;
  logic                    in_rdy;
  logic [IN_C*FW-1:0]      in_feat_pack;
  logic                    w_rd_en;
  logic [1:0]              w_in_c_idx;
  logic [OUT_C*WW-1:0]     w_vec_pack;
  logic                    out_vld;
  logic                    out_rdy;
  logic [OUT_C*ACC-1:0]    out_acc_pack;

  w_mac_seq #(
    .IN_C(IN_C), .OUT_C(OUT_C), .W_WIDTH(WW), .F_WIDTH(FW), .ACC_WIDTH(ACC)
  ) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_feat_pack(in_feat_pack), .w_rd_en(w_rd_en), .w_in_c_idx(w_in_c_idx),
    .w_vec_pack(w_vec_pack), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_acc_pack(out_acc_pack)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Weight memory with one-cycle read latency; garbage when not reading
  int mem [IN_C][OUT_C];
  always @(posedge clk) begin
    logic [OUT_C*WW-1:0] row;
    row = OUT_C*WW'($urandom);
    if (w_rd_en) begin
      for (int j = 0; j < OUT_C; j++) row[j*WW +: WW] = WW'(mem[w_in_c_idx][j]);
    end
    w_vec_pack <= row;
  end

  // Behavioural model: timeline since accept plus dot-product results
  bit m_busy = 0, m_out = 0;
  int m_cnt = 0;
  int m_exp [OUT_C];
  int cyc = 0, acc_cyc = 0, prev_acc_cyc = 0, acc_count = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_out = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (in_vld) begin
        for (int j = 0; j < OUT_C; j++) begin
          int sum;
          logic signed [FW-1:0]  f;
          logic signed [ACC-1:0] t;
          sum = 0;
          for (int k = 0; k < IN_C; k++) begin
            f = in_feat_pack[k*FW +: FW];
            sum += int'(f) * mem[k][j];
          end
          t = ACC'(sum);
          m_exp[j] = int'(t);
        end
        m_busy = 1; m_cnt = 0;
        prev_acc_cyc = acc_cyc; acc_cyc = cyc; acc_count++;
      end
    end else if (m_out) begin
      if (out_rdy) begin m_busy = 0; m_out = 0; end
    end else begin
      m_cnt++;
      if (m_cnt == IN_C + 1) m_out = 1;
    end
    cyc++;
  end

  function automatic int lane(input logic [OUT_C*ACC-1:0] p, input int j);
    logic signed [ACC-1:0] t;
    t = p[j*ACC +: ACC];
    return int'(t);
  endfunction

  // Per-cycle compare of DUT against the model
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_rd;
      exp_rd = m_busy && !m_out && (m_cnt < IN_C);
      chk("in_rdy", int'(in_rdy), int'(!m_busy));
      chk("out_vld", int'(out_vld), int'(m_out));
      chk("w_rd_en", int'(w_rd_en), int'(exp_rd));
      if (exp_rd) chk("w_in_c_idx", int'(w_in_c_idx), m_cnt);
      if (m_out) begin
        for (int j = 0; j < OUT_C; j++) chk("lane_sum", lane(out_acc_pack, j), m_exp[j]);
      end
    end
  end

  function automatic logic [IN_C*FW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {FW'(d), FW'(c), FW'(b), FW'(a)};
  endfunction

  task automatic fill_mem(input int v0, input int v1);
    for (int k = 0; k < IN_C; k++) begin mem[k][0] = v0; mem[k][1] = v1; end
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 100 && acc_count < target; i++) begin @(posedge clk); #1; end
    chk("accept_timeout", int'(acc_count >= target), 1);
  endtask

  task automatic wait_out(output logic [OUT_C*ACC-1:0] cap);
    bit got = 0;
    cap = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (out_vld) begin cap = out_acc_pack; got = 1; end
    end
    chk("out_timeout", int'(got), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && m_busy; i++) begin @(posedge clk); #1; end
    chk("idle_timeout", int'(m_busy), 0);
  endtask

  // Offer one vector and follow it to the completed output handshake
  task automatic run_one(input logic [IN_C*FW-1:0] fp, input bit rnd, input int hold,
                         output logic [OUT_C*ACC-1:0] cap, output int lat,
                         output int rdcnt, output int vcyc);
    int start;
    bit accd, done;
    start = acc_count; accd = 0; done = 0;
    lat = -1; rdcnt = 0; vcyc = 0; cap = '0;
    in_feat_pack = fp; in_vld = 1'b1;
    if (hold > 0) out_rdy = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      if (!accd && acc_count != start) begin
        accd = 1; in_vld = 1'b0; in_feat_pack = IN_C*FW'($urandom);
      end
      if (accd && !m_busy) begin
        done = 1;
      end else begin
        if (vcyc < hold)  out_rdy = 1'b0;
        else if (rnd)     out_rdy = 1'($urandom_range(0, 1));
        else              out_rdy = 1'b1;
        @(negedge clk);
        if (w_rd_en) rdcnt++;
        if (out_vld) begin
          if (lat < 0) begin lat = cyc - acc_cyc; cap = out_acc_pack; end
          vcyc++;
        end
      end
    end
    chk("run_timeout", int'(done), 1);
    out_rdy = 1'b1;
  endtask

  initial begin
    logic [OUT_C*ACC-1:0] cap;
    int lat, rdcnt, vcyc;

    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1; in_feat_pack = '0;
    fill_mem(0, 0);
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_rdy", int'(in_rdy), 1);
    chk("rst_out_vld", int'(out_vld), 0);
    chk("rst_w_rd_en", int'(w_rd_en), 0);
    chk("rst_idx", int'(w_in_c_idx), 0);
    chk("rst_acc", int'(out_acc_pack == '0), 1);
    rst = 1'b0;

    // Basic: 1+2+3+4 with unit weights, latency and read count
    fill_mem(1, 1);
    run_one(pack4(1, 2, 3, 4), 0, 0, cap, lat, rdcnt, vcyc);
    chk("basic_l0", lane(cap, 0), 10);
    chk("basic_l1", lane(cap, 1), 10);
    chk("basic_latency", lat, IN_C + 2);
    chk("basic_rd_cycles", rdcnt, 4);

    // Signed extremes
    fill_mem(-128, -128);
    run_one(pack4(-128, -128, -128, -128), 0, 0, cap, lat, rdcnt, vcyc);
    chk("ext_neg_l0", lane(cap, 0), 65536);
    chk("ext_neg_l1", lane(cap, 1), 65536);
    fill_mem(127, 127);
    run_one(pack4(-128, -128, -128, -128), 0, 0, cap, lat, rdcnt, vcyc);
    chk("ext_pos_l0", lane(cap, 0), -65024);
    chk("ext_pos_l1", lane(cap, 1), -65024);

    // Mixed-sign lanes
    for (int k = 0; k < IN_C; k++) begin mem[k][0] = k + 1; mem[k][1] = -(k + 1); end
    run_one(pack4(1, 1, 1, 1), 0, 0, cap, lat, rdcnt, vcyc);
    chk("mixed_l0", lane(cap, 0), 10);
    chk("mixed_l1", lane(cap, 1), -10);

    // Backpressure: 5 stalled cycles in OUT then accept
    fill_mem(2, 2);
    run_one(pack4(1, 2, 3, 4), 0, 5, cap, lat, rdcnt, vcyc);
    chk("bp_l0", lane(cap, 0), 20);
    chk("bp_vld_cycles", vcyc, 6);
    chk("bp_after_in_rdy", int'(in_rdy), 1);
    chk("bp_after_out_vld", int'(out_vld), 0);

    // Reset in the middle of the row walk
    fill_mem(9, -9);
    in_feat_pack = pack4(7, 7, 7, 7); in_vld = 1'b1;
    wait_acc(acc_count + 1);
    in_vld = 1'b0;
    begin
      bit hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
        @(negedge clk);
        if (w_rd_en && w_in_c_idx == 2'd2) hit = 1;
      end
      chk("rst_mid_reach_idx2", int'(hit), 1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_w_rd_en", int'(w_rd_en), 0);
    chk("rst_mid_out_vld", int'(out_vld), 0);
    chk("rst_mid_in_rdy", int'(in_rdy), 1);
    rst = 1'b0;
    fill_mem(2, 2);
    run_one(pack4(1, 1, 1, 1), 0, 0, cap, lat, rdcnt, vcyc);
    chk("post_rst_l0", lane(cap, 0), 8);
    chk("post_rst_l1", lane(cap, 1), 8);

    // Back-to-back with in_vld held high
    fill_mem(3, 3);
    in_feat_pack = pack4(5, 5, 5, 5); in_vld = 1'b1; out_rdy = 1'b1;
    wait_acc(acc_count + 1);
    in_feat_pack = pack4(1, 1, 1, 1);
    wait_acc(acc_count + 1);
    in_vld = 1'b0;
    chk("b2b_spacing", acc_cyc - prev_acc_cyc, IN_C + 3);
    wait_out(cap);
    chk("b2b_l0", lane(cap, 0), 12);
    chk("b2b_l1", lane(cap, 1), 12);
    wait_idle();

    // Random vectors, random weights, random backpressure
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < IN_C; k++)
        for (int j = 0; j < OUT_C; j++) mem[k][j] = $urandom_range(0, 255) - 128;
      run_one(IN_C*FW'($urandom), 1, 0, cap, lat, rdcnt, vcyc);
      chk("rnd_latency", lat, IN_C + 2);
      chk("rnd_rd_cycles", rdcnt, IN_C);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
